comparador_histeresis: RTL and testbench
========================================

COMPARADOR_HISTERESIS -- requirements
Module: comparador_histeresis

Interface
REQ-001 Parameter N, default 5: data and threshold width in bits.
REQ-002 Parameter HYST, default 2: hysteresis band in LSBs, range 0..2^N-1.
REQ-003 Parameter CNT, default 3: consecutive qualifying samples needed to change the output, range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sample_en  input  1  when high, the current d is evaluated this cycle.
REQ-007 d  input  N  measured value (unsigned).
REQ-008 a  input  N  threshold value (unsigned).
REQ-009 mode  input  2  compare mode: 0 = d>=a, 1 = d>a, 2 = d<=a, 3 = d==a.
REQ-010 clear  input  1  synchronous flush of the filter to the deasserted state.
REQ-011 l  output  1  filtered, hysteretic compare result (registered).
REQ-012 l_raw  output  1  unfiltered compare result of the last sample (registered).
REQ-013 rise  output  1  one-cycle pulse when l goes 0->1.
REQ-014 fall  output  1  one-cycle pulse when l goes 1->0.

Function
REQ-015 All arithmetic is unsigned; thresholds are computed in N+1 bits.
REQ-016 Assert condition, evaluated with sample_en=1 only, is the raw compare selected by mode.
REQ-017 Release condition: modes 0/1: d < a-HYST; mode 2: d > a+HYST; mode 3: d != a (no hysteresis).
REQ-018 If a-HYST < 0 (modes 0/1) or a+HYST > 2^N-1 (mode 2), release never occurs; l stays 1 until clear or reset.
REQ-019 l_raw updates on every sample_en=1 cycle to the mode compare of d against a; it holds otherwise.
REQ-020 FSM states: LOW, PEND_HI, HIGH, PEND_LO; 8-bit sample counter.
REQ-021 LOW: a qualifying assert sample goes to PEND_HI with count=1; if CNT=1, goes directly to HIGH.
REQ-022 PEND_HI: an assert sample increments count; on reaching CNT, goes to HIGH and resets count to 0; a non-qualifying sample goes to LOW with count 0.
REQ-023 HIGH/PEND_LO: mirror of REQ-021/022 using the release condition, returning to LOW.
REQ-024 sample_en=0: state, count and outputs hold.
REQ-025 l=1 exactly in HIGH and PEND_LO; l changes on the clock edge that accepts the CNT-th qualifying sample, visible the following cycle.
REQ-026 rise/fall assert for exactly the one cycle in which l first shows its new value.
REQ-027 mode and a are applied per sample with no extra latency; a change while pending does not clear the count unless it makes the current sample non-qualifying.
REQ-028 clear=1 has priority over sample_en: it goes to LOW with count=0 and l=0, clears l_raw, and generates no fall pulse.

Reset
REQ-029 reset_n=0 asynchronously forces LOW, count=0, and l=l_raw=rise=fall=0, regardless of clk.
REQ-030 Reset during PEND_HI/PEND_LO discards the partial count; after release, CNT fresh samples are required.

Verification (N=5, HYST=2, CNT=3)
REQ-031 Reset pulse mid-run -> all outputs 0 immediately; first post-reset sample with d=31, a=0, mode 0 gives l_raw=1, l=0.
REQ-032 mode 0, a=20: d=21 x3 -> l=1 with a one-cycle rise after the 3rd; d=19 x3 -> l stays 1; d=17 x3 -> l=0 with a one-cycle fall.
REQ-033 mode 0, a=20: d=21,21,10,21,21 -> l=0 throughout; one more d=21 -> l=1.
REQ-034 mode 0, a=1: d=5 x3 -> l=1; d=0 x5 -> l stays 1; clear -> l=0, no fall pulse.
REQ-035 mode 3, a=7: d=7 x3 -> l=1; d=8 x3 -> l=0. mode 2, a=30: d=10 x3 -> l=1; d=31 x5 -> l stays 1.
REQ-036 sample_en low for 10 cycles between the 2nd and 3rd qualifying samples -> l changes only on the 3rd sample.

Source files
------------

// File: rtl/comparador_histeresis_if.sv
// Bundles the sample/threshold inputs and the filtered compare outputs.
// Clock and reset are kept as plain ports on the comparator.
interface comparador_histeresis_if #(
  parameter int N = 5
) ();
  logic         sample_en;
  logic [N-1:0] d;
  logic [N-1:0] a;
  logic [1:0]   mode;
  logic         clear;
  logic         l;
  logic         l_raw;
  logic         rise;
  logic         fall;

  modport master (
    output sample_en, d, a, mode, clear,
    input  l, l_raw, rise, fall
  );

  modport slave (
    input  sample_en, d, a, mode, clear,
    output l, l_raw, rise, fall
  );
endinterface

// File: rtl/comparador_histeresis.sv
// Hysteretic comparator with a consecutive-sample debounce filter.
// The raw compare is selected by mode. The filtered output l only changes
// after CNT consecutive qualifying samples.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOW     | l=0, waiting for an assert sample
// PEND_HI | l=0, counting consecutive assert samples toward CNT
// HIGH    | l=1, waiting for a release sample
// PEND_LO | l=1, counting consecutive release samples toward CNT
module comparador_histeresis #(
  parameter int N    = 5,
  parameter int HYST = 2,
  parameter int CNT  = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  comparador_histeresis_if.slave    bus
);

  typedef enum logic [1:0] {LOW, PEND_HI, HIGH, PEND_LO} state_t;

  localparam logic [N:0] HYST_W = (N+1)'(HYST);
  localparam logic [7:0] CNT_W  = 8'(CNT);

  state_t     state;
  logic [7:0] count;
  logic [7:0] count_inc;
  logic       at_cnt;
  logic [N:0] d_w;
  logic [N:0] a_w;
  logic       hit;
  logic       rel;
  logic       l_q;
  logic       raw_q;
  logic       rise_q;
  logic       fall_q;

  assign d_w = {1'b0, bus.d};
  assign a_w = {1'b0, bus.a};

  // count is held at 0 in LOW/HIGH, so the same terminal compare also
  // covers the CNT=1 case where the first sample switches directly.
  assign count_inc = count + 8'd1;
  assign at_cnt    = (count_inc == CNT_W);

  // Assert and release conditions for the selected mode. The release
  // thresholds are rearranged (d+HYST < a, d > a+HYST) in N+1 bits, so an
  // out-of-range band can never be satisfied and release never happens.
  always_comb begin
    hit = 1'b0;
    rel = 1'b0;
    case (bus.mode)
      2'd0: begin
        hit = (d_w >= a_w);
        rel = ((d_w + HYST_W) < a_w);
      end
      2'd1: begin
        hit = (d_w > a_w);
        rel = ((d_w + HYST_W) < a_w);
      end
      2'd2: begin
        hit = (d_w <= a_w);
        rel = (d_w > (a_w + HYST_W));
      end
      default: begin
        hit = (d_w == a_w);
        rel = (d_w != a_w);
      end
    endcase
  end

  // Filter FSM with registered l, l_raw and single-cycle edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= LOW;
      count  <= 8'd0;
      l_q    <= 1'b0;
      raw_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (bus.clear) begin
        state <= LOW;
        count <= 8'd0;
        l_q   <= 1'b0;
        raw_q <= 1'b0;
      end else if (bus.sample_en) begin
        raw_q <= hit;
        case (state)
          LOW, PEND_HI: begin
            if (hit) begin
              if (at_cnt) begin
                state  <= HIGH;
                count  <= 8'd0;
                l_q    <= 1'b1;
                rise_q <= 1'b1;
              end else begin
                state <= PEND_HI;
                count <= count_inc;
              end
            end else begin
              state <= LOW;
              count <= 8'd0;
            end
          end
          HIGH, PEND_LO: begin
            if (rel) begin
              if (at_cnt) begin
                state  <= LOW;
                count  <= 8'd0;
                l_q    <= 1'b0;
                fall_q <= 1'b1;
              end else begin
                state <= PEND_LO;
                count <= count_inc;
              end
            end else begin
              state <= HIGH;
              count <= 8'd0;
            end
          end
          default: begin
            state <= LOW;
            count <= 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.l     = l_q;
  assign bus.l_raw = raw_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;

endmodule

// File: tb/tb_comparador_histeresis.sv
// Bench for comparador_histeresis (N=5, HYST=2, CNT=3). The driver pushes
// the hand-computed output tuple {l, l_raw, rise, fall} expected after each
// clock edge; the monitor pops and compares on the following falling edge.
module tb_comparador_histeresis;

  logic clk;
  logic reset_n;

  comparador_histeresis_if #(.N(5)) bus ();

  comparador_histeresis #(.N(5), .HYST(2), .CNT(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] exp;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: l/raw/rise/fall got=%b expected=%b", nm, got, exp);
    end
  endtask

  // Monitor: compare outputs against the oldest pending expectation.
  always @(negedge clk) begin
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, {bus.l, bus.l_raw, bus.rise, bus.fall}, e.exp);
    end
  end

  task automatic push(input string nm, input logic [3:0] e);
    sb_t s;
    s.name = nm;
    s.exp  = e;
    sb.push_back(s);
  endtask

  task automatic samp(input string nm, input logic [4:0] dv, input logic [3:0] e);
    bus.sample_en = 1'b1;
    bus.clear     = 1'b0;
    bus.d         = dv;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    push(nm, e);
  endtask

  task automatic idle(input string nm, input logic [3:0] e);
    bus.sample_en = 1'b0;
    bus.clear     = 1'b0;
    @(posedge clk);
    #1;
    push(nm, e);
  endtask

  task automatic do_clear(input string nm, input logic [3:0] e);
    bus.sample_en = 1'b1;
    bus.clear     = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
    bus.clear     = 1'b0;
    push(nm, e);
  endtask

  task automatic set_cmp(input logic [1:0] m, input logic [4:0] av);
    bus.mode = m;
    bus.a    = av;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.sample_en = 1'b0;
    bus.clear     = 1'b0;
    bus.d         = 5'd0;
    bus.a         = 5'd0;
    bus.mode      = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle("reset_state", 4'b0000);

    // mode 0, a=20: rise after 3rd d=21, hold inside band, fall on d=17
    set_cmp(2'd0, 5'd20);
    samp("m0_up1", 5'd21, 4'b0100);
    samp("m0_up2", 5'd21, 4'b0100);
    samp("m0_up3_rise", 5'd21, 4'b1110);
    idle("m0_rise_one_cycle", 4'b1100);
    for (int i = 0; i < 3; i++) samp("m0_band_hold", 5'd19, 4'b1000);
    samp("m0_dn1", 5'd17, 4'b1000);
    samp("m0_dn2", 5'd17, 4'b1000);
    samp("m0_dn3_fall", 5'd17, 4'b0001);
    idle("m0_fall_one_cycle", 4'b0000);

    // interrupted run restarts the count
    samp("intr_1", 5'd21, 4'b0100);
    samp("intr_2", 5'd21, 4'b0100);
    samp("intr_break", 5'd10, 4'b0000);
    samp("intr_4", 5'd21, 4'b0100);
    samp("intr_5", 5'd21, 4'b0100);
    samp("intr_6_rise", 5'd21, 4'b1110);
    // aborted release: a non-qualifying sample in PEND_LO goes back to HIGH
    samp("plo_1", 5'd17, 4'b1000);
    samp("plo_abort", 5'd19, 4'b1000);
    samp("plo_a", 5'd17, 4'b1000);
    samp("plo_b", 5'd17, 4'b1000);
    samp("plo_c_fall", 5'd17, 4'b0001);

    // mode 1 (strict): d==a does not assert
    set_cmp(2'd1, 5'd20);
    samp("m1_equal", 5'd20, 4'b0000);
    samp("m1_up1", 5'd21, 4'b0100);
    samp("m1_up2", 5'd21, 4'b0100);
    samp("m1_up3_rise", 5'd21, 4'b1110);
    samp("m1_edge_band", 5'd18, 4'b1000);
    samp("m1_dn1", 5'd17, 4'b1000);
    samp("m1_dn2", 5'd17, 4'b1000);
    samp("m1_dn3_fall", 5'd17, 4'b0001);

    // mode 0, a=1: a-HYST negative, release never happens; clear drops l
    set_cmp(2'd0, 5'd1);
    samp("lowa_1", 5'd5, 4'b0100);
    samp("lowa_2", 5'd5, 4'b0100);
    samp("lowa_3_rise", 5'd5, 4'b1110);
    for (int i = 0; i < 5; i++) samp("lowa_no_release", 5'd0, 4'b1000);
    do_clear("lowa_clear_no_fall", 4'b0000);
    idle("lowa_after_clear", 4'b0000);

    // mode 3, a=7
    set_cmp(2'd3, 5'd7);
    samp("m3_1", 5'd7, 4'b0100);
    samp("m3_2", 5'd7, 4'b0100);
    samp("m3_3_rise", 5'd7, 4'b1110);
    samp("m3_ne1", 5'd8, 4'b1000);
    samp("m3_ne2", 5'd8, 4'b1000);
    samp("m3_ne3_fall", 5'd8, 4'b0001);

    // mode 2, a=30: a+HYST exceeds 31, release never happens
    set_cmp(2'd2, 5'd30);
    samp("m2_1", 5'd10, 4'b0100);
    samp("m2_2", 5'd10, 4'b0100);
    samp("m2_3_rise", 5'd10, 4'b1110);
    for (int i = 0; i < 5; i++) samp("m2_no_release", 5'd31, 4'b1000);
    do_clear("m2_clear", 4'b0000);

    // sample_en gap between 2nd and 3rd qualifying sample
    set_cmp(2'd0, 5'd20);
    samp("gap_1", 5'd21, 4'b0100);
    samp("gap_2", 5'd21, 4'b0100);
    bus.d = 5'd0;
    for (int i = 0; i < 10; i++) idle("gap_hold", 4'b0100);
    samp("gap_3_rise", 5'd21, 4'b1110);
    do_clear("gap_clear", 4'b0000);

    // reset in PEND_HI: asynchronous clear and a fresh count afterwards
    samp("rst_pend1", 5'd21, 4'b0100);
    samp("rst_pend2", 5'd21, 4'b0100);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", {bus.l, bus.l_raw, bus.rise, bus.fall}, 4'b0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_cmp(2'd0, 5'd0);
    samp("post_rst_1", 5'd31, 4'b0100);
    samp("post_rst_2", 5'd31, 4'b0100);
    samp("post_rst_3_rise", 5'd31, 4'b1110);
    idle("post_rst_idle", 4'b1100);

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
